output_buffer: RTL and testbench

// - Output capture stage of the SPAD iTOF pixel readout. Takes the two 12-bit
//   tap counts (memory1 = tap A, memory2 = tap B) from the per-pixel counter

---
 rtl/itof_pkg.sv | 15 +
 rtl/output_buffer_reg.sv | 20 ++
 rtl/output_buffer.sv | 49 ++++
 tb/tb_output_buffer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/itof_pkg.sv
// Shared iTOF readout definitions: tap count width, packed phase word type,
// and the saturation test used wherever a tap count is captured.
package itof_pkg;

  localparam int CNT_W = 12;
  localparam int OUT_W = 2 * CNT_W;

  typedef logic [OUT_W-1:0] phase_word_t;

  // A tap is saturated when its counter has run to all ones.
  function automatic logic tap_saturated(input logic [CNT_W-1:0] count);
    return count == {CNT_W{1'b1}};
  endfunction

endpackage

// File: rtl/output_buffer_reg.sv
// Generic WIDTH-bit register with load enable and asynchronous active-high clear.
module output_buffer_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/output_buffer.sv
// Output capture stage of the SPAD iTOF pixel readout: packs tap A / tap B
// counts into one phase word and holds it stable between readout strobes.
module output_buffer
  import itof_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] memory1,
  input  logic [CNT_W-1:0] memory2,
  input  logic             en,
  output logic [OUT_W-1:0] phase_out,
  output logic             out_valid,
  output logic             sat
);

  // out_valid is a one-cycle qualifier with no ready: it is high exactly in
  // the cycle after an edge that loaded phase_out/sat, and the consumer must
  // take the word then or rely on it being held until the next capture.

  logic        sat_next;
  phase_word_t word_next;
  logic [OUT_W:0] stored;

  assign sat_next  = tap_saturated(memory1) | tap_saturated(memory2);
  assign word_next = {memory1, memory2};

  // sat travels in the same register as the word so the two never disagree.
  output_buffer_reg #(
    .WIDTH(OUT_W + 1)
  ) u_word_reg (
    .clk(clk),
    .rst(rst),
    .en (en),
    .d  ({sat_next, word_next}),
    .q  (stored)
  );

  assign sat       = stored[OUT_W];
  assign phase_out = stored[OUT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= en;
    end
  end

endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer: reset, capture, hold, tracking,
// saturation and bit ordering of the packed phase word.
module tb_output_buffer;

  logic        clk;
  logic        rst;
  logic [11:0] memory1;
  logic [11:0] memory2;
  logic        en;
  logic [23:0] phase_out;
  logic        out_valid;
  logic        sat;

  int checks;
  int failures;

  output_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .memory1  (memory1),
    .memory2  (memory2),
    .en       (en),
    .phase_out(phase_out),
    .out_valid(out_valid),
    .sat      (sat)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: change inputs on the falling edge, sample 1 ns after rising
  task automatic drive(input logic [11:0] m1, input logic [11:0] m2, input logic e);
    @(negedge clk);
    memory1 = m1;
    memory2 = m2;
    en      = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (phase_out !== 24'h0 || out_valid !== 1'b0 || sat !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial: phase_out=%h out_valid=%b sat=%b expected 000000/0/0",
               phase_out, out_valid, sat);
    end
    drive(12'd0, 12'd0, 1'b0);
    rst = 1'b0;
    drive(12'hFFF, 12'd200, 1'b1);
    tick();
    checks++;
    if (phase_out !== 24'hFFF0C8 || sat !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_precapture: phase_out=%h sat=%b out_valid=%b expected fff0c8/1/1",
               phase_out, sat, out_valid);
    end
    drive(12'd100, 12'd200, 1'b1);
    tick();
    // asynchronous reset mid-stream, no clock edge in between
    rst = 1'b1;
    #1;
    checks++;
    if (phase_out !== 24'h0 || out_valid !== 1'b0 || sat !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: phase_out=%h out_valid=%b sat=%b expected 000000/0/0",
               phase_out, out_valid, sat);
    end
    tick();
    checks++;
    if (phase_out !== 24'h0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins: phase_out=%h out_valid=%b expected 000000/0", phase_out, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (phase_out !== 24'h0640C8 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_capture: phase_out=%h out_valid=%b expected 0640c8/1",
               phase_out, out_valid);
    end
    drive(12'd0, 12'd0, 1'b0);
    tick();
  endtask

  task automatic test_capture();
    drive(12'd0, 12'd0, 1'b1);
    tick();
    drive(12'd100, 12'd200, 1'b1);
    @(negedge clk);
    en = 1'b0;
    #1;
    checks++;
    if (phase_out !== 24'h0640C8 || out_valid !== 1'b1 || sat !== 1'b0) begin
      failures++;
      $display("FAIL capture_value: phase_out=%h out_valid=%b sat=%b expected 0640c8/1/0",
               phase_out, out_valid, sat);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL capture_pulse_width: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_hold();
    drive(12'd5, 12'd4, 1'b0);
    tick();
    tick();
    checks++;
    if (phase_out !== 24'h0640C8 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold: phase_out=%h out_valid=%b expected 0640c8/0", phase_out, out_valid);
    end
  endtask

  task automatic test_tracking();
    drive(12'd100, 12'd200, 1'b1);
    tick();
    drive(12'd5, 12'd4, 1'b1);
    #1;
    checks++;
    if (phase_out !== 24'h0640C8) begin
      failures++;
      $display("FAIL tracking_latency: phase_out=%h expected 0640c8", phase_out);
    end
    tick();
    checks++;
    if (phase_out !== 24'h005004 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL tracking_update: phase_out=%h out_valid=%b expected 005004/1",
               phase_out, out_valid);
    end
    drive(12'd7, 12'd9, 1'b1);
    tick();
    checks++;
    if (phase_out !== 24'h007009 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL tracking_continuous: phase_out=%h out_valid=%b expected 007009/1",
               phase_out, out_valid);
    end
  endtask

  task automatic test_saturation();
    drive(12'hFFF, 12'h000, 1'b1);
    tick();
    checks++;
    if (phase_out !== 24'hFFF000 || sat !== 1'b1) begin
      failures++;
      $display("FAIL sat_tap_a: phase_out=%h sat=%b expected fff000/1", phase_out, sat);
    end
    drive(12'd1, 12'd1, 1'b1);
    tick();
    checks++;
    if (phase_out !== 24'h001001 || sat !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear: phase_out=%h sat=%b expected 001001/0", phase_out, sat);
    end
    drive(12'hFFE, 12'hFFF, 1'b1);
    tick();
    checks++;
    if (phase_out !== 24'hFFEFFF || sat !== 1'b1) begin
      failures++;
      $display("FAIL sat_tap_b: phase_out=%h sat=%b expected ffefff/1", phase_out, sat);
    end
    drive(12'd0, 12'd0, 1'b0);
    tick();
    checks++;
    if (sat !== 1'b1 || phase_out !== 24'hFFEFFF) begin
      failures++;
      $display("FAIL sat_hold: phase_out=%h sat=%b expected ffefff/1", phase_out, sat);
    end
    drive(12'hFFE, 12'h7FF, 1'b1);
    tick();
    checks++;
    if (sat !== 1'b0) begin
      failures++;
      $display("FAIL sat_near_full: sat=%b expected 0", sat);
    end
  endtask

  task automatic test_bit_placement();
    drive(12'h800, 12'h001, 1'b1);
    tick();
    checks++;
    if (phase_out !== 24'h800001) begin
      failures++;
      $display("FAIL bit_placement: phase_out=%h expected 800001", phase_out);
    end
    drive(12'h001, 12'h800, 1'b1);
    tick();
    checks++;
    if (phase_out !== 24'h001800) begin
      failures++;
      $display("FAIL bit_placement_swap: phase_out=%h expected 001800", phase_out);
    end
    drive(12'h000, 12'h000, 1'b0);
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    memory1  = '0;
    memory2  = '0;
    en       = 1'b0;
    rst      = 1'b1;
    test_reset();
    test_capture();
    test_hold();
    test_tracking();
    test_saturation();
    test_bit_placement();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
